// File: rtl/wb_stage_if.sv
// MEM/WB boundary bundle: MEM-side inputs, data-memory read word and register-file write outputs.
// master = pipeline / MEM side, slave = wb_stage.
interface wb_stage_if #(
    parameter int XLEN = 32
);
    // en/clear: en=0 freezes the stage; clear=1 with en=1 loads a bubble.
    // There is no per-transfer valid/ready pair; valid_m marks a real instruction.
    logic            en;
    logic            clear;
    logic            valid_m;
    logic            reg_write_m;
    logic            mem_to_reg_m;
    logic [2:0]      load_type_m;
    logic [4:0]      rd_m;
    logic [XLEN-1:0] result_m;
    logic [XLEN-1:0] dmem_rdata;

    logic            reg_write_w;
    logic [4:0]      rd_w;
    logic [XLEN-1:0] wd_w;
    logic            valid_w;

    modport master (
        output en, clear, valid_m, reg_write_m, mem_to_reg_m, load_type_m,
               rd_m, result_m, dmem_rdata,
        input  reg_write_w, rd_w, wd_w, valid_w
    );

    modport slave (
        input  en, clear, valid_m, reg_write_m, mem_to_reg_m, load_type_m,
               rd_m, result_m, dmem_rdata,
        output reg_write_w, rd_w, wd_w, valid_w
    );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with stall-safe load-data capture and load alignment/extension.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_stage #(
    parameter int XLEN      = 32,
    parameter int RET_CNT_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_stage_if.slave            wb
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [RET_CNT_W-1:0] retire_cnt
`endif
);

    localparam logic [2:0] LT_LB  = 3'b000;
    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LBU = 3'b100;
    localparam logic [2:0] LT_LHU = 3'b101;

    logic            valid_q, valid_d;
    logic            reg_write_q, reg_write_d;
    logic            mem_to_reg_q, mem_to_reg_d;
    logic [2:0]      load_type_q, load_type_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic            hold_vld_q, hold_vld_d;

    logic [XLEN-1:0] raw_word;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_ext;

    // Stage register next state: flush wins over load, stall holds everything.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        mem_to_reg_d = mem_to_reg_q;
        load_type_d  = load_type_q;
        rd_d         = rd_q;
        result_d     = result_q;
        if (wb.en) begin
            if (wb.clear) begin
                valid_d      = 1'b0;
                reg_write_d  = 1'b0;
                mem_to_reg_d = 1'b0;
                load_type_d  = '0;
                rd_d         = '0;
                result_d     = '0;
            end else begin
                valid_d      = wb.valid_m;
                reg_write_d  = wb.reg_write_m;
                mem_to_reg_d = wb.mem_to_reg_m;
                load_type_d  = wb.load_type_m;
                rd_d         = wb.rd_m;
                result_d     = wb.result_m;
            end
        end
    end

    // The memory word is captured on the first frozen edge so wd_w cannot drift mid-stall.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        if (wb.en) begin
            hold_vld_d = 1'b0;
        end else if (!hold_vld_q) begin
            hold_data_d = wb.dmem_rdata;
            hold_vld_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
            load_type_q  <= '0;
            rd_q         <= '0;
            result_q     <= '0;
            hold_data_q  <= '0;
            hold_vld_q   <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            mem_to_reg_q <= mem_to_reg_d;
            load_type_q  <= load_type_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            hold_data_q  <= hold_data_d;
            hold_vld_q   <= hold_vld_d;
        end
    end

    assign raw_word = hold_vld_q ? hold_data_q : wb.dmem_rdata;

    // Little-endian lane select; halfword ignores address bit 0.
    always_comb begin
        ld_byte = raw_word[7:0];
        case (result_q[1:0])
            2'd0:    ld_byte = raw_word[7:0];
            2'd1:    ld_byte = raw_word[15:8];
            2'd2:    ld_byte = raw_word[23:16];
            default: ld_byte = raw_word[31:24];
        endcase
        ld_half = result_q[1] ? raw_word[31:16] : raw_word[15:0];
    end

    always_comb begin
        load_ext = raw_word;
        case (load_type_q)
            LT_LB:   load_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LT_LBU:  load_ext = {{(XLEN-8){1'b0}}, ld_byte};
            LT_LH:   load_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
            LT_LHU:  load_ext = {{(XLEN-16){1'b0}}, ld_half};
            default: load_ext = raw_word;
        endcase
    end

    assign wb.wd_w        = mem_to_reg_q ? load_ext : result_q;
    assign wb.reg_write_w = valid_q & reg_write_q & (rd_q != 5'd0);
    assign wb.rd_w        = rd_q;
    assign wb.valid_w     = valid_q;

`ifdef WB_RETIRE_CNT_EN
    logic [RET_CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // One count per instruction actually leaving WB; a frozen WB does not retire.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (valid_q && wb.en) begin
            retire_cnt_d = retire_cnt_q + RET_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    logic unused_ret_cfg;
    assign unused_ret_cfg = (RET_CNT_W == 0);
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU write-back, load extension, stall hold, flush,
// and (with WB_RETIRE_CNT_EN) the retire counter at two widths.
module tb_wb_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_stage_if wb ();

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
    logic [3:0]  retire_cnt4;
    wb_stage_if wb4 ();

    assign wb4.en           = wb.en;
    assign wb4.clear        = wb.clear;
    assign wb4.valid_m      = wb.valid_m;
    assign wb4.reg_write_m  = wb.reg_write_m;
    assign wb4.mem_to_reg_m = wb.mem_to_reg_m;
    assign wb4.load_type_m  = wb.load_type_m;
    assign wb4.rd_m         = wb.rd_m;
    assign wb4.result_m     = wb.result_m;
    assign wb4.dmem_rdata   = wb.dmem_rdata;

    wb_stage u_dut (.clk(clk), .rst(rst), .wb(wb.slave), .retire_cnt(retire_cnt));
    wb_stage #(.RET_CNT_W(4)) u_dut4 (.clk(clk), .rst(rst), .wb(wb4.slave), .retire_cnt(retire_cnt4));
`else
    wb_stage u_dut (.clk(clk), .rst(rst), .wb(wb.slave));
`endif

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [2:0] lt,
                         input logic [4:0] rd, input logic [31:0] res);
        wb.valid_m      = v;
        wb.reg_write_m  = rw;
        wb.mem_to_reg_m = m2r;
        wb.load_type_m  = lt;
        wb.rd_m         = rd;
        wb.result_m     = res;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    logic [2:0]  ld_lt   [9] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b101, 3'b011};
    logic [1:0]  ld_addr [9] = '{2'd1, 2'd3, 2'd2, 2'd2, 2'd0, 2'd3, 2'd3, 2'd1, 2'd2};
    logic [31:0] ld_exp  [9] = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_00F1, 32'hFFFF_80F1,
                                 32'h0000_7F02, 32'h80F1_7F02, 32'hFFFF_80F1, 32'h0000_7F02,
                                 32'h80F1_7F02};

    initial begin
        // Reset with random inputs
        rst = 1'b1;
        wb.en = 1'($urandom_range(0, 1));
        wb.clear = 1'($urandom_range(0, 1));
        wb.dmem_rdata = $urandom;
        drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 5'($urandom_range(1, 31)), $urandom);
        cycle();
        cycle();
        check_eq("rst_reg_write", 64'(wb.reg_write_w), 64'd0);
        check_eq("rst_rd", 64'(wb.rd_w), 64'd0);
        check_eq("rst_valid", 64'(wb.valid_w), 64'd0);
        check_eq("rst_wd", 64'(wb.wd_w), 64'd0);

        rst = 1'b0;
        wb.en = 1'b1;
        wb.clear = 1'b0;

        // ALU write-back
        drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd5, 32'h1234_5678);
        cycle();
        check_eq("alu_reg_write", 64'(wb.reg_write_w), 64'd1);
        check_eq("alu_rd", 64'(wb.rd_w), 64'd5);
        check_eq("alu_wd", 64'(wb.wd_w), 64'h1234_5678);
        check_eq("alu_valid", 64'(wb.valid_w), 64'd1);

        drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd0, 32'h1234_5678);
        cycle();
        check_eq("rd0_reg_write", 64'(wb.reg_write_w), 64'd0);

        drive(1'b0, 1'b1, 1'b0, 3'b010, 5'd5, 32'hDEAD_BEEF);
        cycle();
        check_eq("bubble_reg_write", 64'(wb.reg_write_w), 64'd0);
        check_eq("bubble_valid", 64'(wb.valid_w), 64'd0);

        // Loads from a fixed memory word
        wb.dmem_rdata = 32'h80F1_7F02;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 1'b1, ld_lt[i], 5'd3, {30'h0000_0400, ld_addr[i]});
            exp_q.push_back(ld_exp[i]);
            cycle();
            check_eq($sformatf("load_%0d_lt%0b_a%0d", i, ld_lt[i], ld_addr[i]),
                     64'(wb.wd_w), 64'(exp_q.pop_front()));
        end

        // Stall: load data must survive memory output changing
        wb.dmem_rdata = 32'hAAAA_5555;
        drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h0000_0100);
        cycle();
        check_eq("stall_pre_wd", 64'(wb.wd_w), 64'hAAAA_5555);
        wb.en = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd7, 32'h0000_0011);
        cycle();
        wb.dmem_rdata = 32'h0;
        check_eq("stall_1_wd", 64'(wb.wd_w), 64'hAAAA_5555);
        cycle();
        check_eq("stall_2_wd", 64'(wb.wd_w), 64'hAAAA_5555);
        cycle();
        check_eq("stall_3_wd", 64'(wb.wd_w), 64'hAAAA_5555);
        check_eq("stall_3_rd", 64'(wb.rd_w), 64'd9);
        wb.en = 1'b1;
        cycle();
        check_eq("stall_exit_rd", 64'(wb.rd_w), 64'd7);
        check_eq("stall_exit_wd", 64'(wb.wd_w), 64'h0000_0011);

        // Flush with en=1
        wb.clear = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd12, 32'h0000_0022);
        cycle();
        check_eq("flush_valid", 64'(wb.valid_w), 64'd0);
        check_eq("flush_reg_write", 64'(wb.reg_write_w), 64'd0);
        check_eq("flush_wd", 64'(wb.wd_w), 64'd0);

        // Flush during stall is deferred
        wb.clear = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd13, 32'h0000_0033);
        cycle();
        check_eq("pre_sflush_rd", 64'(wb.rd_w), 64'd13);
        wb.en = 1'b0;
        wb.clear = 1'b1;
        cycle();
        cycle();
        check_eq("sflush_hold_valid", 64'(wb.valid_w), 64'd1);
        check_eq("sflush_hold_reg_write", 64'(wb.reg_write_w), 64'd1);
        check_eq("sflush_hold_rd", 64'(wb.rd_w), 64'd13);
        check_eq("sflush_hold_wd", 64'(wb.wd_w), 64'h0000_0033);
        wb.en = 1'b1;
        cycle();
        check_eq("sflush_apply_valid", 64'(wb.valid_w), 64'd0);
        check_eq("sflush_apply_reg_write", 64'(wb.reg_write_w), 64'd0);

        // Reset in the middle of a stall
        wb.clear = 1'b0;
        wb.dmem_rdata = 32'h0000_5A5A;
        drive(1'b1, 1'b1, 1'b1, 3'b010, 5'd14, 32'h0000_0040);
        cycle();
        wb.en = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        check_eq("rst_stall_valid", 64'(wb.valid_w), 64'd0);
        check_eq("rst_stall_reg_write", 64'(wb.reg_write_w), 64'd0);
        check_eq("rst_stall_rd", 64'(wb.rd_w), 64'd0);
        check_eq("rst_stall_wd", 64'(wb.wd_w), 64'd0);
        rst = 1'b0;
        wb.en = 1'b1;

`ifdef WB_RETIRE_CNT_EN
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("ret_rst", retire_cnt, 64'd0);
        // 10 valid, bubbles at slots 3/7/10, 2-cycle stall after slot 5
        for (int i = 0; i < 13; i++) begin
            drive((i != 3) && (i != 7) && (i != 10), 1'b1, 1'b0, 3'b010, 5'd1, 32'(i));
            cycle();
            if (i == 5) begin
                wb.en = 1'b0;
                cycle();
                cycle();
                wb.en = 1'b1;
            end
        end
        drive(1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0);
        cycle();
        check_eq("ret_cnt10", retire_cnt, 64'd10);
        check_eq("ret_cnt10_w4", 64'(retire_cnt4), 64'd10);
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b1, 1'b0, 3'b010, 5'd2, 32'(i));
            cycle();
        end
        drive(1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'd0);
        cycle();
        check_eq("ret_cnt17", retire_cnt, 64'd17);
        check_eq("ret_cnt17_w4_wrap", 64'(retire_cnt4), 64'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
